// File: rtl/axi_wr_arb_pkg.sv
// Shared types and helpers for the AXI4 write-path arbiter.
// aw_req_t is sized for the default address/ID/length widths.
package axi_wr_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int ID_W_DEF   = 4;
    localparam int LEN_W_DEF  = 8;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [ID_W_DEF-1:0]   id;
        logic [LEN_W_DEF-1:0]  len;
    } aw_req_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_ord_fifo.sv
// Small synchronous FIFO holding the grant order (requester indices)
// so the W channel can be steered in the same order AW was granted.
module axi_ord_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge ACLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI4 AW arbiter with registered output stage; W beats are
// steered combinationally in grant order via the order FIFO.
module axi_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int ID_WIDTH   = ID_W_DEF,
    parameter int LEN_WIDTH  = LEN_W_DEF,
    parameter int DATA_WIDTH = 32,
    parameter int ORD_DEPTH  = 4,
    localparam int IDX_W     = idx_w(NUM_REQ),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_REQ-1:0]            s_awvalid,
    output logic [NUM_REQ-1:0]            s_awready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_awaddr,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   s_awid,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  s_awlen,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic [ID_WIDTH+IDX_W-1:0]     m_awid,
    output logic [LEN_WIDTH-1:0]          m_awlen,
    input  logic [NUM_REQ-1:0]            s_wvalid,
    output logic [NUM_REQ-1:0]            s_wready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_REQ*STRB_W-1:0]     s_wstrb,
    input  logic [NUM_REQ-1:0]            s_wlast,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [STRB_W-1:0]             m_wstrb,
    output logic                          m_wlast
);

    typedef enum logic {ST_IDLE, ST_ISSUE} aw_state_t;

    aw_state_t        state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] aw_idx_q;
    logic [IDX_W-1:0] head;
    logic             found;
    logic             grant;
    logic             ord_full;
    logic             ord_empty;
    logic             ord_pop;
    aw_req_t          win_req;
    aw_req_t          aw_q;

    // Scan upward from the RR pointer, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && s_awvalid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Reset gates the grant so s_awready is quiet while ARESETn is low.
    assign grant = ARESETn && (state == ST_IDLE) && found && !ord_full;

    always_comb begin
        s_awready = '0;
        if (grant) s_awready[winner] = 1'b1;
        win_req.addr = s_awaddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        win_req.id   = s_awid[int'(winner)*ID_WIDTH +: ID_WIDTH];
        win_req.len  = s_awlen[int'(winner)*LEN_WIDTH +: LEN_WIDTH];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            m_awvalid <= 1'b0;
            aw_q      <= '0;
            aw_idx_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        aw_q      <= win_req;
                        aw_idx_q  <= winner;
                        rr_ptr    <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + IDX_W'(1);
                        m_awvalid <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_awaddr = aw_q.addr;
    assign m_awid   = {aw_idx_q, aw_q.id};
    assign m_awlen  = aw_q.len;

    axi_ord_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (ORD_DEPTH)
    ) u_ord_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (grant),
        .din     (winner),
        .pop     (ord_pop),
        .dout    (head),
        .full    (ord_full),
        .empty   (ord_empty),
        .count   ()
    );

    // Only the requester at the head of the grant order sees the W path.
    always_comb begin
        m_wvalid = 1'b0;
        s_wready = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_wlast  = 1'b0;
        if (!ord_empty) begin
            m_wvalid = s_wvalid[head];
            if (m_wready) s_wready[head] = 1'b1;
            m_wdata  = s_wdata[int'(head)*DATA_WIDTH +: DATA_WIDTH];
            m_wstrb  = s_wstrb[int'(head)*STRB_W +: STRB_W];
            m_wlast  = s_wlast[head];
        end
    end

    assign ord_pop = m_wvalid & m_wready & m_wlast;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_axi_wr_arbiter;

    localparam int NR  = 4;
    localparam int ORD = 4;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [3:0]    s_awvalid, s_awready;
    logic [127:0]  s_awaddr;
    logic [15:0]   s_awid;
    logic [31:0]   s_awlen;
    logic          m_awvalid, m_awready;
    logic [31:0]   m_awaddr;
    logic [5:0]    m_awid;
    logic [7:0]    m_awlen;
    logic [3:0]    s_wvalid, s_wready;
    logic [127:0]  s_wdata;
    logic [15:0]   s_wstrb;
    logic [3:0]    s_wlast;
    logic          m_wvalid, m_wready;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wlast;

    int checks = 0;
    int errors = 0;

    // Reference model state: RR pointer, pending downstream AW, grant order.
    int          mdl_rr = 0;
    bit          mdl_pend = 0;
    logic [31:0] mdl_addr;
    logic [5:0]  mdl_id;
    logic [7:0]  mdl_len;
    int          mdl_ord[$];

    always #5 ACLK = ~ACLK;

    axi_wr_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awid(s_awid), .s_awlen(s_awlen),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast)
    );

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] awv, input logic awr,
                                 input logic [3:0] wv, input logic [3:0] wl, input logic wr);
        ARESETn   = rst;
        s_awvalid = awv;
        m_awready = awr;
        s_wvalid  = wv;
        s_wlast   = wl;
        m_wready  = wr;
    endtask

    task automatic setAw(input int r, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        s_awaddr[r*32 +: 32] = a;
        s_awid[r*4 +: 4]     = id;
        s_awlen[r*8 +: 8]    = len;
    endtask

    task automatic setW(input int r, input logic [31:0] d, input logic [3:0] st);
        s_wdata[r*32 +: 32] = d;
        s_wstrb[r*4 +: 4]   = st;
    endtask

    // Compare every output against the model, then advance the model by one edge.
    task automatic checkOutput();
        int          win;
        int          h;
        bit          can_grant;
        bit          exp_wv, exp_last, do_pop;
        logic [3:0]  exp_awr, exp_wr, exp_strb;
        logic [31:0] exp_data;
        if (!ARESETn) begin
            mdl_rr   = 0;
            mdl_pend = 0;
            mdl_ord.delete();
        end
        win = -1;
        for (int i = 0; i < NR; i++) begin
            if (win < 0 && s_awvalid[(mdl_rr + i) % NR]) win = (mdl_rr + i) % NR;
        end
        can_grant = ARESETn && !mdl_pend && (win >= 0) && (mdl_ord.size() < ORD);
        exp_awr = '0;
        if (can_grant) exp_awr[win] = 1'b1;
        checkValue("s_awready", s_awready, exp_awr);
        checkValue("m_awvalid", m_awvalid, mdl_pend);
        if (!ARESETn) begin
            checkValue("m_awaddr_rst", m_awaddr, 0);
            checkValue("m_awid_rst", m_awid, 0);
            checkValue("m_awlen_rst", m_awlen, 0);
        end else if (mdl_pend) begin
            checkValue("m_awaddr", m_awaddr, mdl_addr);
            checkValue("m_awid", m_awid, mdl_id);
            checkValue("m_awlen", m_awlen, mdl_len);
        end
        exp_wv = 0; exp_wr = '0; exp_data = '0; exp_strb = '0; exp_last = 0;
        if (mdl_ord.size() > 0) begin
            h        = mdl_ord[0];
            exp_wv   = s_wvalid[h];
            if (m_wready) exp_wr[h] = 1'b1;
            exp_data = s_wdata[h*32 +: 32];
            exp_strb = s_wstrb[h*4 +: 4];
            exp_last = s_wlast[h];
        end
        checkValue("m_wvalid", m_wvalid, exp_wv);
        checkValue("s_wready", s_wready, exp_wr);
        checkValue("m_wdata", m_wdata, exp_data);
        checkValue("m_wstrb", m_wstrb, exp_strb);
        checkValue("m_wlast", m_wlast, exp_last);
        if (ARESETn) begin
            do_pop = exp_wv && m_wready && exp_last;
            if (mdl_pend && m_awready) mdl_pend = 0;
            if (do_pop) void'(mdl_ord.pop_front());
            if (can_grant) begin
                mdl_pend = 1;
                mdl_addr = s_awaddr[win*32 +: 32];
                mdl_id   = {2'(win), s_awid[win*4 +: 4]};
                mdl_len  = s_awlen[win*8 +: 8];
                mdl_rr   = (win + 1) % NR;
                mdl_ord.push_back(win);
            end
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        checkOutput();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [3:0] randBits(input int pct);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    initial begin
        int order[$];
        int g;
        s_awaddr = '0; s_awid = '0; s_awlen = '0; s_wdata = '0; s_wstrb = '0;
        applyStimulus(0, 4'hF, 1, 4'hF, 4'hF, 1);
        #2;
        checkValue("rst_awready", s_awready, 0);
        checkValue("rst_awvalid", m_awvalid, 0);
        checkValue("rst_wvalid", m_wvalid, 0);
        checkValue("rst_wready", s_wready, 0);
        tick();

        // Single requester 2 with a 4-beat burst.
        setAw(2, 32'h1000, 4'h3, 8'h3);
        applyStimulus(1, 4'b0100, 1, 4'b0000, 4'b0000, 1);
        #1 checkValue("d1_grant", s_awready, 4'b0100);
        tick();
        applyStimulus(1, 4'b0000, 1, 4'b0000, 4'b0000, 1);
        #1;
        checkValue("d1_awvalid", m_awvalid, 1);
        checkValue("d1_awid", m_awid, 6'h23);
        checkValue("d1_awaddr", m_awaddr, 32'h1000);
        checkValue("d1_awlen", m_awlen, 8'h3);
        tick();
        for (int b = 0; b < 4; b++) begin
            setW(2, 32'hD000 + 32'(b), 4'hF);
            applyStimulus(1, 4'b0000, 1, 4'b0100, (b == 3) ? 4'b0100 : 4'b0000, 1);
            #1;
            checkValue("d1_wvalid", m_wvalid, 1);
            checkValue("d1_wready", s_wready, 4'b0100);
            checkValue("d1_wdata", m_wdata, 32'hD000 + 32'(b));
            tick();
        end
        applyStimulus(1, 4'b0000, 1, 4'b0100, 4'b0000, 1);
        #1 checkValue("d1_popped", s_wready, 4'b0000);
        tick();

        // All requesters valid from reset: order 0,1,2,3 then FIFO full.
        applyStimulus(0, 4'hF, 1, 4'h0, 4'h0, 0);
        tick();
        applyStimulus(1, 4'hF, 1, 4'h0, 4'h0, 0);
        for (int c = 0; c < 10; c++) begin
            #1;
            for (int k = 0; k < NR; k++) if (s_awready[k]) order.push_back(k);
            tick();
        end
        checkValue("d2_grant_count", order.size(), 4);
        for (int k = 0; k < 4; k++) begin
            g = (k < order.size()) ? order[k] : -1;
            checkValue("d2_grant_order", g, k);
        end
        applyStimulus(1, 4'hF, 1, 4'b0001, 4'b0001, 1);
        #1;
        checkValue("d2_full_no_grant", s_awready, 4'b0000);
        checkValue("d2_pop_beat", m_wvalid, 1);
        tick();
        applyStimulus(1, 4'hF, 1, 4'h0, 4'h0, 1);
        #1 checkValue("d2_resume", s_awready, 4'b0001);
        tick();

        // Downstream stall during ISSUE with W beats running ahead of AW.
        applyStimulus(0, 4'h0, 0, 4'h0, 4'h0, 1);
        tick();
        setAw(0, 32'hA0, 4'h5, 8'h2);
        applyStimulus(1, 4'b0001, 0, 4'h0, 4'h0, 1);
        tick();
        for (int c = 0; c < 5; c++) begin
            setW(0, 32'hBEEF0000 + 32'(c), 4'hA);
            applyStimulus(1, 4'b0011, 0, (c < 3) ? 4'b0001 : 4'b0000, (c == 2) ? 4'b0001 : 4'b0000, 1);
            #1;
            checkValue("d3_awaddr", m_awaddr, 32'hA0);
            checkValue("d3_awid", m_awid, 6'h05);
            checkValue("d3_awlen", m_awlen, 8'h2);
            checkValue("d3_no_grant", s_awready, 4'b0000);
            if (c < 3) begin
                checkValue("d3_wdata", m_wdata, 32'hBEEF0000 + 32'(c));
                checkValue("d3_wstrb", m_wstrb, 4'hA);
                checkValue("d3_wvalid", m_wvalid, 1);
            end
            tick();
        end
        applyStimulus(1, 4'b0011, 1, 4'h0, 4'h0, 1);
        #1 checkValue("d3_still_valid", m_awvalid, 1);
        tick();
        #1;
        checkValue("d3_dropped", m_awvalid, 0);
        checkValue("d3_next_rr", s_awready, 4'b0010);
        tick();

        // Reset during beat 2 of a 4-beat burst.
        applyStimulus(0, 4'h0, 1, 4'h0, 4'h0, 1);
        tick();
        setAw(0, 32'h2000, 4'h1, 8'h3);
        applyStimulus(1, 4'b0001, 1, 4'h0, 4'h0, 1);
        tick();
        applyStimulus(1, 4'b0000, 1, 4'h0, 4'h0, 1);
        tick();
        setW(0, 32'h11, 4'hF);
        applyStimulus(1, 4'b0000, 1, 4'b0001, 4'h0, 1);
        tick();
        setW(0, 32'h22, 4'hF);
        applyStimulus(1, 4'hF, 1, 4'b0001, 4'h0, 1);
        #1 checkValue("d4_beat2_wvalid", m_wvalid, 1);
        applyStimulus(0, 4'hF, 1, 4'b0001, 4'h0, 1);
        #1;
        checkValue("d4_rst_wvalid", m_wvalid, 0);
        checkValue("d4_rst_wready", s_wready, 0);
        checkValue("d4_rst_wdata", m_wdata, 0);
        checkValue("d4_rst_awready", s_awready, 0);
        checkValue("d4_rst_awaddr", m_awaddr, 0);
        tick();
        applyStimulus(1, 4'hF, 1, 4'h0, 4'h0, 1);
        #1;
        checkValue("d4_first_grant", s_awready, 4'b0001);
        checkValue("d4_fifo_empty", s_wready, 4'b0000);
        tick();

        // Randomized traffic in three density regimes.
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 1200; c++) begin
                logic [3:0] awv;
                for (int r = 0; r < NR; r++) begin
                    setAw(r, $urandom, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                    setW(r, $urandom, 4'($urandom_range(0, 15)));
                end
                case (p)
                    0:       awv = ($urandom_range(0, 2) == 0) ? randBits(25) : 4'h0;
                    1:       awv = 4'hF;
                    default: awv = 4'($urandom_range(0, 15));
                endcase
                applyStimulus($urandom_range(0, 299) != 0, awv, $urandom_range(0, 3) != 0,
                              randBits(60), randBits(33), $urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
